// File: rtl/prm_voxel_feeder.sv
// -----------------------------------------------------------------------------
// prm_voxel_feeder
//
// Upstream stage of the PRM edge-collision checker. Keeps a writable list of
// occupied obstacle voxels (packed {x,y,z}) and, on start, plays every voxel
// to the checker once for each of the eight edge-mask partitions (sel1 0..7).
// Each coordinate is held stable for SETTLE cycles. sample_strb marks the
// cycle in which the checker result for that voxel/partition may be captured.
//
// Handshake: there is no backpressure. A sweep is requested by a one-cycle
// start pulse while busy = 0. Results are qualified by sample_strb alone.
// abort cancels a running sweep on the next edge and produces no done pulse.
//
// Ports:
//   CLK, RST      clock, synchronous active-high reset
//   wr_en/addr/data  voxel list write port (ignored while busy)
//   num_voxels    number of voxels to sweep, clamped to 2**AW, sampled on start
//   start, abort  sweep control
//   busy          sweep in progress (FETCH, WAIT, DONE)
//   done          one-cycle pulse after the final sample
//   xyzInput      coordinate presented to the checker
//   xyz_valid     xyzInput holds the current voxel
//   sel1          current partition index
//   sample_strb   checker output settled for current voxel/partition
//   last_strb     sample_strb of the final voxel of the final partition
// -----------------------------------------------------------------------------
module prm_voxel_feeder #(
    parameter int XW     = 4,
    parameter int YW     = 5,
    parameter int ZW     = 5,
    parameter int AW     = 8,
    parameter int SETTLE = 2
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  wr_en,
    input  logic [AW-1:0]         wr_addr,
    input  logic [XW+YW+ZW-1:0]   wr_data,
    input  logic [AW:0]           num_voxels,
    input  logic                  start,
    input  logic                  abort,
    output logic                  busy,
    output logic                  done,
    output logic [XW+YW+ZW-1:0]   xyzInput,
    output logic                  xyz_valid,
    output logic [2:0]            sel1,
    output logic                  sample_strb,
    output logic                  last_strb
);

    localparam int VW = XW + YW + ZW;
    localparam int DEPTH = 2 ** AW;
    localparam logic [AW:0] DEPTH_N = (AW + 1)'(DEPTH);
    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // state is kept as a named signal so checkers can bind to it directly
    state_t state;
    state_t state_nxt;

    logic [VW-1:0] mem [DEPTH];

    logic [AW:0]   n_q;
    logic [AW-1:0] idx_q;
    logic [2:0]    part_q;
    logic [3:0]    cnt_q;
    logic [VW-1:0] xyz_q;

    logic [AW:0]   n_clamped;
    logic [AW:0]   n_last;
    logic          start_ok;
    logic          idx_last;
    logic          part_last;
    logic          wait_end;

    assign n_clamped = (num_voxels > DEPTH_N) ? DEPTH_N : num_voxels;
    assign n_last    = n_q - 1'b1;
    assign start_ok  = start && !abort;
    assign idx_last  = ({1'b0, idx_q} == n_last);
    assign part_last = (part_q == 3'd7);
    assign wait_end  = (state == S_WAIT) && (cnt_q == SETTLE_LAST);

    // ---------------------------------------------------------------- list RAM
    // Writes are refused while a sweep is running so the list seen by one
    // sweep is consistent from its first voxel to its last.
    always_ff @(posedge CLK) begin
        if (wr_en && !busy) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // ---------------------------------------------------------- state register
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------- next state
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (start_ok) begin
                    state_nxt = (n_clamped == '0) ? S_DONE : S_FETCH;
                end
            end
            S_FETCH: begin
                state_nxt = abort ? S_IDLE : S_WAIT;
            end
            S_WAIT: begin
                if (abort) begin
                    state_nxt = S_IDLE;
                end else if (wait_end) begin
                    state_nxt = (idx_last && part_last) ? S_DONE : S_FETCH;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // ---------------------------------------------------------------- outputs
    always_comb begin
        busy        = (state != S_IDLE);
        done        = (state == S_DONE);
        xyz_valid   = (state == S_WAIT);
        sample_strb = wait_end;
        last_strb   = wait_end && idx_last && part_last;
        sel1        = part_q;
        xyzInput    = xyz_q;
    end

    // --------------------------------------------------------------- datapath
    // xyz_q is the synchronous read register of the list: it loads once at the
    // FETCH->WAIT edge and then holds through the whole settle window.
    // part/idx advance only when a sample completes without abort, so they
    // never run past N-1 and 7.
    always_ff @(posedge CLK) begin
        if (RST) begin
            n_q    <= '0;
            idx_q  <= '0;
            part_q <= '0;
            cnt_q  <= '0;
            xyz_q  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start_ok) begin
                        n_q    <= n_clamped;
                        idx_q  <= '0;
                        part_q <= '0;
                    end
                end
                S_FETCH: begin
                    cnt_q <= '0;
                    xyz_q <= mem[idx_q];
                end
                S_WAIT: begin
                    if (wait_end) begin
                        if (!abort) begin
                            if (idx_last) begin
                                if (!part_last) begin
                                    part_q <= part_q + 3'd1;
                                    idx_q  <= '0;
                                end
                            end else begin
                                idx_q <= idx_q + 1'b1;
                            end
                        end
                    end else begin
                        cnt_q <= cnt_q + 4'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: doc/prm_voxel_feeder.md
Name: prm_voxel_feeder

Overview:
- Upstream stage of the PRM edge-collision checker. Holds a loadable list of occupied obstacle voxels, each a packed {x,y,z} coordinate.
- On start, streams every voxel to the checker's xyzInput once per edge-mask partition (sel1 = 0..7).
- Holds each coordinate stable for a configurable settle time and pulses sample_strb when the checker result may be captured downstream.

Parameters:
- XW, 4, x coordinate width
- YW, 5, y coordinate width
- ZW, 5, z coordinate width
- AW, 8, voxel list address width; list depth = 2**AW
- SETTLE, 2, cycles each coordinate is held valid before sampling; legal range 1..15

Ports:
- CLK  in  1  clock
- RST  in  1  synchronous active-high reset
- wr_en  in  1  voxel list write strobe
- wr_addr  in  AW  voxel list write address
- wr_data  in  XW+YW+ZW  packed {x,y,z} voxel
- num_voxels  in  AW+1  voxel count; sampled on accepted start
- start  in  1  begin sweep (accepted only in IDLE)
- abort  in  1  cancel sweep
- busy  out  1  sweep in progress
- done  out  1  one-cycle pulse at completed sweep
- xyzInput  out  XW+YW+ZW  coordinate to checker
- xyz_valid  out  1  xyzInput is the current voxel
- sel1  out  3  current partition index
- sample_strb  out  1  one-cycle pulse: checker output is settled for current voxel/partition
- last_strb  out  1  coincides with sample_strb on the final voxel of the final partition

Behaviour:
- Everything is synchronous to CLK. RST clears all outputs and counters: busy, done, xyz_valid, sample_strb and last_strb = 0; xyzInput = 0; sel1 = 0; state = IDLE. List contents are not cleared.
- Voxel list: DEPTH x (XW+YW+ZW) RAM with a synchronous write port and a synchronous read port (1-cycle read latency).
- Writes are accepted only when busy = 0; a write while busy is dropped.
- States:
  - IDLE: if start and not abort, latch N = num_voxels, idx = 0, part = 0.
    - N = 0 -> DONE.
    - Otherwise -> FETCH.
  - FETCH: present read address idx; xyz_valid = 0. -> WAIT.
  - WAIT: xyzInput = read data, registered at WAIT entry and held constant; xyz_valid = 1; cnt counts 0..SETTLE-1.
    - sample_strb = 1 in the cycle cnt = SETTLE-1.
    - In that cycle: if idx = N-1 and part = 7 -> DONE with last_strb = 1. If idx = N-1 and part < 7 -> part++, idx = 0, FETCH. Otherwise idx++, FETCH.
  - DONE: done = 1 for exactly one cycle, xyz_valid = 0. -> IDLE.
- busy = 1 in FETCH, WAIT and DONE; busy = 0 in IDLE.
- sel1 = part and changes only on the FETCH entry that starts a new partition. sel1 is therefore stable throughout every WAIT.
- Timing:
  - start accepted at edge t -> FETCH during cycle t+1 -> first xyz_valid at t+2.
  - Each voxel costs 1+SETTLE cycles.
  - A full sweep takes 8*N*(1+SETTLE) cycles from first FETCH to DONE. The done pulse follows in the next cycle.
- N > 2**AW: N is clamped to 2**AW.
- abort in any non-IDLE state -> IDLE on the next edge. No done, no further sample_strb, xyz_valid drops to 0. abort has priority over start and over a same-cycle sample_strb transition; the strobe itself is still emitted in that cycle.
- start while busy is ignored. start and abort in the same IDLE cycle -> remain IDLE.
- RST mid-sweep: same as abort, plus outputs cleared.
- idx and part never wrap beyond N-1 and 7 respectively.

Test Plan:
- Reset then idle: RST = 1 for 2 cycles, no start -> busy, done, xyz_valid and sample_strb stay 0; sel1 = 0; xyzInput = 0.
- Basic sweep, SETTLE = 2: load addr 0..2 with 0x0001, 0x0A5F, 0x3FFF; N = 3; pulse start.
  - xyzInput sequence 0x0001, 0x0A5F, 0x3FFF repeats for sel1 = 0..7.
  - 24 sample_strb pulses, each 3 cycles apart.
  - last_strb on the 24th pulse only; done exactly 1 cycle after it; busy high for 73 cycles.
- Zero count: N = 0, start -> done pulses 2 cycles after start, no xyz_valid, no sample_strb.
- Abort mid-sweep: N = 4, assert abort during the 5th voxel (sel1 = 1) -> busy = 0 next cycle, no done. A following start runs a full 32-pulse sweep from sel1 = 0, idx = 0.
- Write while busy: during a sweep, write addr 1 = 0x1234 -> addr 1 still yields its prior value on the next sweep. A write after done is taken.
- SETTLE = 1 and N = 256, with num_voxels = 300 -> clamped to 256; 2048 sample_strb, 2 cycles apart; done after 4096 busy cycles.
